mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/rr_pick2.sv | 14 +
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic OWN_P0 = 1'b0;
  localparam logic OWN_P1 = 1'b1;

  localparam int MAX_LEN = 16;
  localparam int CNT_W   = $clog2(MAX_LEN);

  localparam logic [31:0] BEAT_STRIDE = 32'd4;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the port that was not served last wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt0,
  output logic gnt1
);

  // last == 1 means port 1 was served most recently, so port 0 wins a tie
  assign gnt0 = req0 && (!req1 || last);
  assign gnt1 = req1 && (!req0 || !last);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU single-word port (p0) and a DMA burst port (p1) onto one memory.
//   state  | meaning
//   IDLE   | no transfer; requests sampled and arbitrated here
//   ACCESS | one beat per cycle to memory until the beat counter expires
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        Reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [3:0]  p1_len,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_beat,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_done,
  output logic [31:0] mem_access_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_write_en,
  output logic        mem_read,
  input  logic [31:0] mem_read_data,
  output logic        busy
);

  state_t           state_q;
  logic             owner_q;
  logic             we_q;
  logic             last_owner_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic             p0_gnt_q;
  logic             p1_gnt_q;
  logic             p0_rvalid_q;
  logic             p1_rvalid_q;
  logic             p1_done_q;
  logic             pick0;
  logic             pick1;
  logic             in_access;

  rr_pick2 u_pick (
    .req0 (p0_req),
    .req1 (p1_req),
    .last (last_owner_q),
    .gnt0 (pick0),
    .gnt1 (pick1)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_P0;
      we_q         <= 1'b0;
      last_owner_q <= OWN_P1;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
      p0_gnt_q     <= 1'b0;
      p1_gnt_q     <= 1'b0;
      p0_rvalid_q  <= 1'b0;
      p1_rvalid_q  <= 1'b0;
      p1_done_q    <= 1'b0;
    end else begin
      p0_gnt_q    <= 1'b0;
      p1_gnt_q    <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p1_done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick0 || pick1) begin
            state_q      <= ACCESS;
            owner_q      <= pick1 ? OWN_P1 : OWN_P0;
            last_owner_q <= pick1 ? OWN_P1 : OWN_P0;
            we_q         <= pick1 ? p1_we : p0_we;
            addr_q       <= pick1 ? p1_addr : p0_addr;
            cnt_q        <= pick1 ? CNT_W'(p1_len) : '0;
            if (pick0) wdata_q <= p0_wdata;
            p0_gnt_q     <= pick0;
            p1_gnt_q     <= pick1;
          end
        end
        ACCESS: begin
          // stride leaves addr[1:0] untouched, wrap is natural 32-bit overflow
          addr_q <= addr_q + BEAT_STRIDE;
          if (!we_q) begin
            rdata_q     <= mem_read_data;
            p0_rvalid_q <= (owner_q == OWN_P0);
            p1_rvalid_q <= (owner_q == OWN_P1);
          end
          if (cnt_q == '0) begin
            state_q   <= IDLE;
            p1_done_q <= (owner_q == OWN_P1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_access = (state_q == ACCESS);

  assign mem_access_addr = in_access ? addr_q : '0;
  assign mem_read        = in_access && !we_q;
  assign mem_write_en    = in_access && we_q && !Reset;
  assign mem_write_data  = !in_access          ? '0 :
                           (owner_q == OWN_P0) ? wdata_q : p1_wdata;

  assign p1_beat   = in_access && (owner_q == OWN_P1);
  assign busy      = (state_q != IDLE);
  assign p0_gnt    = p0_gnt_q;
  assign p1_gnt    = p1_gnt_q;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = rdata_q;
  assign p1_rdata  = rdata_q;
  assign p1_done   = p1_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: read data queued at request time, popped on rvalid.
module tb_mem_arbiter;

  logic        clk;
  logic        Reset;
  logic        p0_req, p0_we;
  logic [31:0] p0_addr, p0_wdata;
  logic        p0_gnt, p0_rvalid;
  logic [31:0] p0_rdata;
  logic        p1_req, p1_we;
  logic [31:0] p1_addr;
  logic [3:0]  p1_len;
  logic [31:0] p1_wdata;
  logic        p1_gnt, p1_beat, p1_rvalid, p1_done;
  logic [31:0] p1_rdata;
  logic [31:0] mem_access_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read, busy;

  logic [31:0] mem   [0:1023];
  logic [31:0] model [0:1023];
  logic [31:0] exp_p0[$];
  logic [31:0] exp_p1[$];
  int          n_pass  = 0;
  int          n_total = 0;
  int          p1_rv_n = 0;

  mem_arbiter dut (
    .clk             (clk),
    .Reset           (Reset),
    .p0_req          (p0_req),
    .p0_we           (p0_we),
    .p0_addr         (p0_addr),
    .p0_wdata        (p0_wdata),
    .p0_gnt          (p0_gnt),
    .p0_rvalid       (p0_rvalid),
    .p0_rdata        (p0_rdata),
    .p1_req          (p1_req),
    .p1_we           (p1_we),
    .p1_addr         (p1_addr),
    .p1_len          (p1_len),
    .p1_wdata        (p1_wdata),
    .p1_gnt          (p1_gnt),
    .p1_beat         (p1_beat),
    .p1_rvalid       (p1_rvalid),
    .p1_rdata        (p1_rdata),
    .p1_done         (p1_done),
    .mem_access_addr (mem_access_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_en    (mem_write_en),
    .mem_read        (mem_read),
    .mem_read_data   (mem_read_data),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_access_addr[11:2]];
  always @(negedge clk) if (mem_write_en) mem[mem_access_addr[11:2]] <= mem_write_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // scoreboard pop on every read response
  always @(negedge clk) begin
    if (p0_rvalid) begin
      if (exp_p0.size() == 0) check_eq("p0_rv_unexpected", 32'd1, 32'd0);
      else check_eq("p0_rdata", p0_rdata, exp_p0.pop_front());
    end
    if (p1_rvalid) begin
      p1_rv_n++;
      if (exp_p1.size() == 0) check_eq("p1_rv_unexpected", 32'd1, 32'd0);
      else check_eq("p1_rdata", p1_rdata, exp_p1.pop_front());
    end
  end

  task automatic p0_op(input logic we, input logic [31:0] addr, input logic [31:0] data);
    int waited;
    @(posedge clk); #1;
    p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = data;
    waited = 0;
    @(posedge clk);
    do begin @(negedge clk); waited++; end while (!p0_gnt && waited < 10);
    check_eq("p0_gnt_lat", waited, 1);
    check_eq("p0_addr", mem_access_addr, addr);
    check_eq("p0_mem_we", mem_write_en, we);
    check_eq("p0_mem_rd", mem_read, !we);
    if (we) begin
      check_eq("p0_wdata", mem_write_data, data);
      model[addr[11:2]] = data;
    end else begin
      exp_p0.push_back(model[addr[11:2]]);
    end
    @(posedge clk); #1;
    p0_req = 1'b0;
    @(negedge clk);
    check_eq("p0_rv_lat", p0_rvalid, !we);
    check_eq("p0_idle_after", busy, 0);
  endtask

  task automatic p1_burst(input logic we, input logic [31:0] addr, input logic [3:0] len,
                          input logic [31:0] base);
    int waited;
    int rv0;
    logic [31:0] a;
    @(posedge clk); #1;
    p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_len = len; p1_wdata = base;
    rv0 = p1_rv_n;
    waited = 0;
    @(posedge clk);
    do begin @(negedge clk); waited++; end while (!p1_gnt && waited < 10);
    check_eq("p1_gnt_lat", waited, 1);
    for (int i = 0; i <= int'(len); i++) begin
      if (i > 0) @(negedge clk);
      a = addr + 32'(4 * i);
      check_eq("p1_beat", p1_beat, 1);
      check_eq("p1_addr", mem_access_addr, a);
      check_eq("p1_done_early", p1_done, 0);
      if (we) begin
        check_eq("p1_wdata", mem_write_data, base + 32'(i));
        model[a[11:2]] = base + 32'(i);
      end else begin
        exp_p1.push_back(model[a[11:2]]);
      end
      @(posedge clk); #1;
      p1_req = 1'b0;
      p1_wdata = base + 32'(i + 1);
    end
    @(negedge clk);
    check_eq("p1_done", p1_done, 1);
    check_eq("p1_beat_end", p1_beat, 0);
    check_eq("p1_busy_end", busy, 0);
    check_eq("p1_done_rv", p1_rvalid, !we);
    #1;
    check_eq("p1_rv_count", p1_rv_n - rv0, we ? 0 : int'(len) + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]   = 32'hC0DE0000 + 32'(i);
      model[i] = 32'hC0DE0000 + 32'(i);
    end
    Reset = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_len = 0; p1_wdata = 0;
    repeat (3) @(posedge clk);
    #1 Reset = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_gnt", {p0_gnt, p1_gnt}, 0);
    check_eq("rst_rdata", p0_rdata, 0);
    check_eq("rst_mem_ctl", {mem_write_en, mem_read, p1_beat, p1_done}, 0);

    // tie after reset: p0 first, then alternation while both keep requesting
    @(posedge clk); #1;
    p0_req = 1; p0_we = 1; p0_addr = 32'h20; p0_wdata = 32'hA5;
    p1_req = 1; p1_we = 1; p1_addr = 32'h40; p1_len = 0; p1_wdata = 32'h5A;
    @(posedge clk);
    @(negedge clk);
    check_eq("tie_p0_gnt", p0_gnt, 1);
    check_eq("tie_p1_wait", p1_gnt, 0);
    model[32'h20 >> 2] = 32'hA5;
    @(negedge clk);
    check_eq("tie_idle_gap", busy, 0);
    @(negedge clk);
    check_eq("rr_p1_gnt", p1_gnt, 1);
    check_eq("rr_p0_wait", p0_gnt, 0);
    check_eq("rr_p1_wdata", mem_write_data, 32'h5A);
    model[32'h40 >> 2] = 32'h5A;
    @(posedge clk); #1;
    p1_req = 0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rr_p0_again", p0_gnt, 1);
    @(posedge clk); #1;
    p0_req = 0;
    @(negedge clk);

    p0_op(1'b1, 32'h10, 32'hDEADBEEF);
    p0_op(1'b0, 32'h10, 32'h0);
    p0_op(1'b0, 32'h40, 32'h0);

    p1_burst(1'b1, 32'h100, 4'd3, 32'd1);
    p1_burst(1'b0, 32'h100, 4'd15, 32'd0);
    p0_op(1'b0, 32'h104, 32'h0);

    // reset lands on the second beat of an 8-beat write burst
    @(posedge clk); #1;
    p1_req = 1; p1_we = 1; p1_addr = 32'h200; p1_len = 4'd7; p1_wdata = 32'h11;
    @(posedge clk);
    @(negedge clk);
    check_eq("rb_gnt", p1_gnt, 1);
    check_eq("rb_beat1_we", mem_write_en, 1);
    model[32'h200 >> 2] = 32'h11;
    @(posedge clk); #1;
    p1_req = 0; p1_wdata = 32'h12; Reset = 1'b1;
    @(negedge clk);
    check_eq("rb_we_in_reset", mem_write_en, 0);
    @(posedge clk); #1;
    Reset = 1'b0;
    @(negedge clk);
    check_eq("rb_busy", busy, 0);
    check_eq("rb_beat", p1_beat, 0);
    for (int k = 0; k < 3; k++) begin
      check_eq("rb_no_done", p1_done, 0);
      @(negedge clk);
    end
    p0_op(1'b0, 32'h204, 32'h0);
    p0_op(1'b0, 32'h200, 32'h0);

    repeat (3) @(negedge clk);
    check_eq("sb_p0_drain", exp_p0.size(), 0);
    check_eq("sb_p1_drain", exp_p1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
